// File: rtl/cva6_fifo_multiport.sv
// cva6_fifo_multiport: multi-port circular FIFO, up to PUSH_PORTS entries in and POP_PORTS entries out per cycle
//   clk_i, rst_ni        clock, asynchronous active-low reset (pointers and count only, memory is not reset)
//   flush_i              synchronous clear, overrides that cycle's pushes and pops
//   push_i, data_i       per-lane push request and data; push_ready_o[k] = more than k free slots
//   pop_i, data_o        per-lane pop request and k-th oldest entry; pop_valid_o[k] = more than k stored entries
//   usage_o, full_o, empty_o, almost_full_o   status derived from the registered count
module cva6_fifo_multiport #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 8,
  parameter int PUSH_PORTS     = 2,
  parameter int POP_PORTS      = 2,
  parameter int ALMOST_FULL_TH = DEPTH - PUSH_PORTS,
  parameter int CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [PUSH_PORTS-1:0]            push_i,
  input  logic [PUSH_PORTS*DATA_WIDTH-1:0] data_i,
  output logic [PUSH_PORTS-1:0]            push_ready_o,
  output logic [POP_PORTS-1:0]             pop_valid_o,
  output logic [POP_PORTS*DATA_WIDTH-1:0]  data_o,
  input  logic [POP_PORTS-1:0]             pop_i,
  output logic [CNT_W-1:0]                 usage_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic                             almost_full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SW = PTR_W + 3;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PUSH_PORTS-1:0] push_acc;
  logic [POP_PORTS-1:0] pop_acc;
  logic [2:0] n_push, n_pop;
  // Offsets never exceed DEPTH, so one conditional subtraction wraps correctly for any DEPTH.
  function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] p, input logic [2:0] n);
    logic [SW-1:0] s;
    s = {3'b000, p} + {{PTR_W{1'b0}}, n};
    return (s >= DEPTH_S) ? PTR_W'(s - DEPTH_S) : PTR_W'(s);
  endfunction
  // Ready/valid come only from the registered count; acceptance is the all-ones request prefix.
  for (genvar k = 0; k < PUSH_PORTS; k++) begin : g_push
    assign push_ready_o[k] = int'(count_q) + k < DEPTH;
    assign push_acc[k] = (&push_i[k:0]) & push_ready_o[k];
  end
  for (genvar k = 0; k < POP_PORTS; k++) begin : g_pop
    assign pop_valid_o[k] = int'(count_q) > k;
    assign pop_acc[k] = (&pop_i[k:0]) & pop_valid_o[k];
    assign data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[wrap(rptr_q, 3'(k))];
  end
  always_comb begin
    n_push = '0;
    n_pop = '0;
    for (int i = 0; i < PUSH_PORTS; i++) n_push += {2'b00, push_acc[i]};
    for (int i = 0; i < POP_PORTS; i++) n_pop += {2'b00, pop_acc[i]};
  end
  always_ff @(posedge clk_i)
    for (int i = 0; i < PUSH_PORTS; i++)
      if (push_acc[i] && !flush_i) mem_q[wrap(wptr_q, 3'(i))] <= data_i[i*DATA_WIDTH +: DATA_WIDTH];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wrap(wptr_q, n_push);
      rptr_q <= wrap(rptr_q, n_pop);
      count_q <= count_q + CNT_W'(n_push) - CNT_W'(n_pop);
    end
  assign usage_o = count_q;
  assign full_o = count_q == CNT_W'(DEPTH);
  assign empty_o = count_q == '0;
  assign almost_full_o = int'(count_q) >= ALMOST_FULL_TH;
endmodule

// File: tb/tb_cva6_fifo_multiport.sv
// tb_cva6_fifo_multiport: directed table-driven check of a DEPTH=5 instance plus hand sequences on a DEPTH=8 instance
module tb_cva6_fifo_multiport;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic f5, f8;
  logic [1:0] p5, q5, r5, v5, p8, q8, r8, v8;
  logic [63:0] d5, o5, d8, o8;
  logic [2:0] u5;
  logic [3:0] u8;
  logic full5, emp5, af5, full8, emp8, af8;
  cva6_fifo_multiport #(.DEPTH(5)) u_d5 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f5), .push_i(p5), .data_i(d5),
    .push_ready_o(r5), .pop_valid_o(v5), .data_o(o5), .pop_i(q5),
    .usage_o(u5), .full_o(full5), .empty_o(emp5), .almost_full_o(af5)
  );
  cva6_fifo_multiport #(.DEPTH(8), .ALMOST_FULL_TH(6)) u_d8 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(f8), .push_i(p8), .data_i(d8),
    .push_ready_o(r8), .pop_valid_o(v8), .data_o(o8), .pop_i(q8),
    .usage_o(u8), .full_o(full8), .empty_o(emp8), .almost_full_o(af8)
  );
  typedef struct {
    logic flush;
    logic [1:0] push;
    logic [31:0] d0, d1;
    logic [1:0] pop;
    int u;
    logic [1:0] rdy, vld;
    logic [31:0] e0, e1;
  } vec_t;
  localparam int NV = 15;
  localparam logic [31:0] A = 32'hA000_0000, B = 32'hB000_0000, C = 32'hC000_0000;
  localparam logic [31:0] D = 32'hD000_0000, E = 32'hE000_0000;
  vec_t tv [NV];
  int n_vec = 0, n_bad = 0;
  function automatic vec_t mk(input logic f, input logic [1:0] p, input logic [31:0] a, b,
                              input logic [1:0] q, input int u, input logic [1:0] r, v,
                              input logic [31:0] e0, e1);
    vec_t t;
    t.flush = f; t.push = p; t.d0 = a; t.d1 = b; t.pop = q;
    t.u = u; t.rdy = r; t.vld = v; t.e0 = e0; t.e1 = e1;
    return t;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, " usage5"}, 32'(u5), 32'd0);
    chk({tag, " empty5"}, 32'(emp5), 32'd1);
    chk({tag, " full5"}, 32'(full5), 32'd0);
    chk({tag, " af5"}, 32'(af5), 32'd0);
    chk({tag, " valid5"}, 32'(v5), 32'd0);
    chk({tag, " ready5"}, 32'(r5), 32'd3);
    chk({tag, " usage8"}, 32'(u8), 32'd0);
    chk({tag, " empty8"}, 32'(emp8), 32'd1);
    chk({tag, " full8"}, 32'(full8), 32'd0);
    chk({tag, " af8"}, 32'(af8), 32'd0);
    chk({tag, " valid8"}, 32'(v8), 32'd0);
    chk({tag, " ready8"}, 32'(r8), 32'd3);
  endtask
  task automatic step8(input logic [1:0] p, input logic [31:0] a, b, input logic [1:0] q);
    p8 = p; d8 = {b, a}; q8 = q;
    @(posedge clk); #1;
    p8 = '0; q8 = '0;
  endtask
  task automatic st8(input string tag, input int u, input logic [1:0] r, v, input logic af);
    chk({tag, " usage"}, 32'(u8), 32'(u));
    chk({tag, " ready"}, 32'(r8), 32'(r));
    chk({tag, " valid"}, 32'(v8), 32'(v));
    chk({tag, " af"}, 32'(af8), 32'(af));
  endtask
  initial begin
    tv[0]  = mk(0, 2'b11, A+0,  A+1,  2'b00, 2, 2'b11, 2'b11, A+0,  A+1);
    tv[1]  = mk(0, 2'b11, A+2,  A+3,  2'b11, 2, 2'b11, 2'b11, A+2,  A+3);
    tv[2]  = mk(0, 2'b11, A+4,  A+5,  2'b11, 2, 2'b11, 2'b11, A+4,  A+5);
    tv[3]  = mk(0, 2'b11, A+6,  A+7,  2'b11, 2, 2'b11, 2'b11, A+6,  A+7);
    tv[4]  = mk(0, 2'b11, A+8,  A+9,  2'b00, 4, 2'b01, 2'b11, A+6,  A+7);
    tv[5]  = mk(0, 2'b11, A+10, A+11, 2'b00, 5, 2'b00, 2'b11, A+6,  A+7);
    tv[6]  = mk(0, 2'b11, B+0,  B+1,  2'b11, 3, 2'b11, 2'b11, A+8,  A+9);
    tv[7]  = mk(0, 2'b00, 0,    0,    2'b11, 1, 2'b11, 2'b01, A+10, 0);
    tv[8]  = mk(0, 2'b10, C+0,  C+1,  2'b00, 1, 2'b11, 2'b01, A+10, 0);
    tv[9]  = mk(0, 2'b11, C+2,  C+3,  2'b00, 3, 2'b11, 2'b11, A+10, C+2);
    tv[10] = mk(0, 2'b00, 0,    0,    2'b10, 3, 2'b11, 2'b11, A+10, C+2);
    tv[11] = mk(0, 2'b01, C+4,  0,    2'b01, 3, 2'b11, 2'b11, C+2,  C+3);
    tv[12] = mk(1, 2'b11, D+0,  D+1,  2'b11, 0, 2'b11, 2'b00, 0,    0);
    tv[13] = mk(0, 2'b01, E+0,  0,    2'b00, 1, 2'b11, 2'b01, E+0,  0);
    tv[14] = mk(0, 2'b11, E+1,  E+2,  2'b01, 2, 2'b11, 2'b11, E+1,  E+2);
    f5 = 0; p5 = '0; q5 = '0; d5 = '0;
    f8 = 0; p8 = '0; q8 = '0; d8 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_chk("reset");
    rst_n = 1;
    for (int i = 0; i < NV; i++) begin
      f5 = tv[i].flush; p5 = tv[i].push; d5 = {tv[i].d1, tv[i].d0}; q5 = tv[i].pop;
      @(posedge clk); #1;
      f5 = 0; p5 = '0; q5 = '0;
      chk($sformatf("v%0d usage", i), 32'(u5), 32'(tv[i].u));
      chk($sformatf("v%0d ready", i), 32'(r5), 32'(tv[i].rdy));
      chk($sformatf("v%0d valid", i), 32'(v5), 32'(tv[i].vld));
      chk($sformatf("v%0d full", i), 32'(full5), 32'(tv[i].u == 5));
      chk($sformatf("v%0d empty", i), 32'(emp5), 32'(tv[i].u == 0));
      chk($sformatf("v%0d af", i), 32'(af5), 32'(tv[i].u >= 3));
      if (tv[i].vld[0]) chk($sformatf("v%0d data0", i), o5[31:0], tv[i].e0);
      if (tv[i].vld[1]) chk($sformatf("v%0d data1", i), o5[63:32], tv[i].e1);
    end
    step8(2'b11, D+1, D+2, 2'b00);
    st8("s8a", 2, 2'b11, 2'b11, 0);
    chk("s8a data0", o8[31:0], D+1);
    chk("s8a data1", o8[63:32], D+2);
    step8(2'b11, D+3, D+4, 2'b00);
    st8("s8b", 4, 2'b11, 2'b11, 0);
    step8(2'b11, D+5, D+6, 2'b00);
    st8("s8c", 6, 2'b11, 2'b11, 1);
    step8(2'b01, D+7, 0, 2'b00);
    st8("s8d", 7, 2'b01, 2'b11, 1);
    step8(2'b00, 0, 0, 2'b01);
    st8("s8e", 6, 2'b11, 2'b11, 1);
    chk("s8e data0", o8[31:0], D+2);
    step8(2'b00, 0, 0, 2'b01);
    st8("s8f", 5, 2'b11, 2'b11, 0);
    chk("s8f data0", o8[31:0], D+3);
    chk("s8f data1", o8[63:32], D+4);
    step8(2'b11, D+8, D+9, 2'b00);
    st8("s8g", 7, 2'b01, 2'b11, 1);
    #1 rst_n = 0;
    #2 rst_chk("midreset");
    #2 rst_n = 1;
    step8(2'b01, E+9, 0, 2'b00);
    st8("s8h", 1, 2'b11, 2'b01, 0);
    chk("s8h data0", o8[31:0], E+9);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
